pwm_servo_capture: RTL and testbench

PWM_SERVO_CAPTURE -- requirements
Module: pwm_servo_capture

---
 rtl/servo_pkg.sv | 23 ++
 rtl/pwm_pulse_meter.sv | 157 +++++++++++++++
 rtl/pwm_servo_capture.sv | 52 +++++
 tb/tb_pwm_servo_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, limits and cycle-conversion helpers for the servo capture block
package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH
  } chan_state_t;

  localparam int ANGLE_MAX     = 180;
  localparam int ACCEPT_MIN_US = 500;
  localparam int ACCEPT_MAX_US = 2500;
  localparam int CNT_W         = 21;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    return int'((longint'(clk_hz) * longint'(us)) / 64'sd1000000);
  endfunction

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return int'((longint'(clk_hz) * longint'(ms)) / 64'sd1000);
  endfunction

endpackage

// File: rtl/pwm_pulse_meter.sv
// rtl/pwm_pulse_meter.sv - one servo channel: sync, optional deglitch (SERVO_CAPTURE_FILTER_EN), width-to-angle, stale timer
module pwm_pulse_meter
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int TIMEOUT_MS   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       servo,
  output logic [7:0] angle,
  output logic       valid,
  output logic       err,
  output logic       stale
);

  localparam int MINC_I = us_to_cycles(CLK_HZ, MIN_PULSE_US);
  localparam int MAXC_I = us_to_cycles(CLK_HZ, MAX_PULSE_US);
  localparam int TPD_I  = (MAXC_I - MINC_I) / ANGLE_MAX;

  localparam logic [CNT_W-1:0] MINC     = CNT_W'(MINC_I);
  localparam logic [CNT_W-1:0] TPD_LAST = CNT_W'(TPD_I - 1);
  localparam logic [CNT_W-1:0] ACC_MIN  = CNT_W'(us_to_cycles(CLK_HZ, ACCEPT_MIN_US));
  localparam logic [CNT_W-1:0] ACC_MAX  = CNT_W'(us_to_cycles(CLK_HZ, ACCEPT_MAX_US));
  localparam logic [CNT_W-1:0] TOC      = CNT_W'(ms_to_cycles(CLK_HZ, TIMEOUT_MS));

  logic       s1, s2, level;
  logic [2:0] fill;
  logic       primed;

`ifdef SERVO_CAPTURE_FILTER_EN
  localparam logic [2:0] PRIME = 3'd5;
  logic [2:0] hist;
  logic       filt_q;

  always_comb begin
    level = filt_q;
    if (hist == {3{s2}}) level = s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= {hist[1:0], s2};
      filt_q <= level;
    end
  end
`else
  localparam logic [2:0] PRIME = 3'd2;
  assign level = s2;
`endif

  // Reset-cleared pipeline stages are not real samples; the FSM ignores them.
  assign primed = (fill == PRIME);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      fill <= '0;
    end else begin
      s1 <= servo;
      s2 <= s1;
      if (!primed) fill <= fill + 3'd1;
    end
  end

  chan_state_t      state, state_n;
  logic [CNT_W-1:0] width, width_n, sub, sub_n, stale_cnt, stale_cnt_n;
  logic [7:0]       deg, deg_n;
  logic             pend_ok, pend_ok_n, pend_bad, pend_bad_n, long_err;

  always_comb begin
    state_n    = state;
    width_n    = width;
    sub_n      = sub;
    deg_n      = deg;
    pend_ok_n  = 1'b0;
    pend_bad_n = 1'b0;
    long_err   = 1'b0;
    case (state)
      WAIT_LOW:  if (primed && !level) state_n = WAIT_RISE;
      WAIT_RISE: begin
        // The rising sample is itself the first high sample.
        if (level) begin
          state_n = HIGH;
          width_n = CNT_W'(1);
          sub_n   = '0;
          deg_n   = '0;
        end
      end
      HIGH: begin
        if (level) begin
          if (width == ACC_MAX) begin
            long_err = 1'b1;
            state_n  = WAIT_LOW;
          end else begin
            width_n = width + CNT_W'(1);
            if (width >= MINC) begin
              if (sub == TPD_LAST) begin
                sub_n = '0;
                if (deg != 8'(ANGLE_MAX)) deg_n = deg + 8'd1;
              end else begin
                sub_n = sub + CNT_W'(1);
              end
            end
          end
        end else begin
          state_n = WAIT_RISE;
          if (width >= ACC_MIN) pend_ok_n = 1'b1;
          else                  pend_bad_n = 1'b1;
        end
      end
      default: state_n = WAIT_LOW;
    endcase
  end

  assign stale_cnt_n = (stale_cnt == TOC) ? TOC : stale_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOW;
      width     <= '0;
      sub       <= '0;
      deg       <= '0;
      pend_ok   <= 1'b0;
      pend_bad  <= 1'b0;
      angle     <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      stale     <= 1'b1;
      stale_cnt <= '0;
    end else begin
      state    <= state_n;
      width    <= width_n;
      sub      <= sub_n;
      deg      <= deg_n;
      pend_ok  <= pend_ok_n;
      pend_bad <= pend_bad_n;
      valid    <= pend_ok;
      err      <= pend_bad | long_err;
      if (pend_ok) begin
        angle     <= deg;
        stale_cnt <= '0;
        stale     <= 1'b0;
      end else begin
        stale_cnt <= stale_cnt_n;
        stale     <= stale | (stale_cnt_n == TOC);
      end
    end
  end

endmodule

// File: rtl/pwm_servo_capture.sv
// rtl/pwm_servo_capture.sv - four-channel servo PWM angle capture; deglitch via SERVO_CAPTURE_FILTER_EN
module pwm_servo_capture
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int TIMEOUT_MS   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       servo1,
  input  logic       servo2,
  input  logic       servo3,
  input  logic       servo4,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic [3:0] valid,
  output logic [3:0] err,
  output logic [3:0] stale
);

  logic [3:0] servo_v;
  logic [7:0] ang [4];

  assign servo_v = {servo4, servo3, servo2, servo1};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    pwm_pulse_meter #(
      .CLK_HZ      (CLK_HZ),
      .MIN_PULSE_US(MIN_PULSE_US),
      .MAX_PULSE_US(MAX_PULSE_US),
      .TIMEOUT_MS  (TIMEOUT_MS)
    ) u_meter (
      .clk  (clk),
      .rst  (rst),
      .servo(servo_v[i]),
      .angle(ang[i]),
      .valid(valid[i]),
      .err  (err[i]),
      .stale(stale[i])
    );
  end

  assign angle1 = ang[0];
  assign angle2 = ang[1];
  assign angle3 = ang[2];
  assign angle4 = ang[3];

endmodule

// File: tb/tb_pwm_servo_capture.sv
// tb/tb_pwm_servo_capture.sv - scoreboard bench for pwm_servo_capture at 1 MHz (1 cycle per us)
module tb_pwm_servo_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       servo1 = 1'b0, servo2 = 1'b0, servo3 = 1'b0, servo4 = 1'b0;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic [3:0] valid, err, stale;
  logic [7:0] ang [4];

  always #5 clk = ~clk;

  pwm_servo_capture #(
    .CLK_HZ      (1_000_000),
    .MIN_PULSE_US(1000),
    .MAX_PULSE_US(2000),
    .TIMEOUT_MS  (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .servo1(servo1),
    .servo2(servo2),
    .servo3(servo3),
    .servo4(servo4),
    .angle1(angle1),
    .angle2(angle2),
    .angle3(angle3),
    .angle4(angle4),
    .valid (valid),
    .err   (err),
    .stale (stale)
  );

  assign ang[0] = angle1;
  assign ang[1] = angle2;
  assign ang[2] = angle3;
  assign ang[3] = angle4;

  typedef struct {
    int ch;
    bit is_err;
    int angle;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  last_ang[4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // TPD = (2000-1000)/180 = 5 cycles per degree at 1 MHz
  function automatic int exp_angle(input int n);
    int a;
    if (n <= 1000) return 0;
    a = (n - 1000) / 5;
    return (a > 180) ? 180 : a;
  endfunction

  task automatic set_servo(input int ch, input logic v);
    case (ch)
      0: servo1 = v;
      1: servo2 = v;
      2: servo3 = v;
      default: servo4 = v;
    endcase
  endtask

  // Drives n high samples; the event lands 4 edges after the last high edge.
  task automatic pulse(input int ch, input int n);
    ev_t e;
    @(posedge clk); #1 set_servo(ch, 1'b1);
    repeat (n) @(posedge clk);
    #1 set_servo(ch, 1'b0);
    e.ch = ch;
    e.at = cyc + 4;
    if (n >= 500 && n <= 2500) begin
      last_ang[ch] = exp_angle(n);
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.angle = last_ang[ch];
    exp_q.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic overlong(input int ch, input int n);
    ev_t e;
    @(posedge clk); #1 set_servo(ch, 1'b1);
    e.ch     = ch;
    e.is_err = 1'b1;
    e.angle  = last_ang[ch];
    e.at     = cyc + 2503;
    exp_q.push_back(e);
    repeat (n) @(posedge clk);
    #1 set_servo(ch, 1'b0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (valid[ch] || err[ch]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: ch%0d valid=%0b err=%0b angle=%0d at cycle %0d required none",
                     ch, valid[ch], err[ch], ang[ch], cyc);
          end else begin
            e = exp_q.pop_front();
            chk("event_channel", ch, e.ch);
            chk("event_err", int'(err[ch]), int'(e.is_err));
            chk("event_valid", int'(valid[ch]), int'(!e.is_err));
            chk("event_angle", int'(ang[ch]), e.angle);
            chk("event_cycle", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_angle1", int'(angle1), 0);
    chk("reset_angle2", int'(angle2), 0);
    chk("reset_angle3", int'(angle3), 0);
    chk("reset_angle4", int'(angle4), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_stale", int'(stale), 15);
    rst = 1'b0;
    gap(10);

    pulse(0, 1450);
    gap(3);
    chk("stale0_before_valid", int'(stale[0]), 1);
    gap(1);
    chk("stale0_cleared_with_valid", int'(stale[0]), 0);
    gap(20);

    pulse(1, 1180); gap(20);
    pulse(1, 2100); gap(20);
    pulse(1, 1000); gap(20);
    pulse(1, 1005); gap(20);
    pulse(1, 1004); gap(20);
    pulse(1, 500);  gap(20);
    pulse(1, 499);  gap(20);
    pulse(1, 2500); gap(20);

    pulse(2, 1250); gap(20);
    pulse(2, 300);  gap(20);
    chk("angle3_held_after_err", int'(angle3), 50);
    overlong(2, 2700); gap(20);
    chk("angle3_held_after_overlong", int'(angle3), 50);
    pulse(2, 1450); gap(20);

    pulse(3, 1100);
    gap(4);
    chk("stale3_at_valid", int'(stale[3]), 0);
    gap(4999);
    chk("stale3_one_before_timeout", int'(stale[3]), 0);
    gap(1);
    chk("stale3_at_timeout", int'(stale[3]), 1);
    gap(20);
    pulse(3, 1000);
    gap(4);
    chk("stale3_cleared_by_pulse", int'(stale[3]), 0);
    gap(20);

    @(posedge clk); #1 servo1 = 1'b1;
    gap(300);
    rst = 1'b1;
    gap(2);
    chk("angle1_after_midpulse_reset", int'(angle1), 0);
    rst = 1'b0;
    last_ang[0] = 0;
    gap(1150);
    servo1 = 1'b0;
    gap(20);
    pulse(0, 1450);
    gap(30);

    chk("events_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
